// File: rtl/sel_feed_fifo.sv
// First-word-fall-through sample FIFO feeding a grant-paced downstream stage.
// Grants arriving on an empty FIFO are counted as underruns (saturating at 255).
module sel_feed_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic          grant,
    output logic [7:0]    d,
    output logic          d_valid,
    output logic [AW:0]   level,
    output logic [7:0]    underrun_cnt
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // in_ready looks only at level: a grant never frees a slot within the same cycle.
    assign in_ready = (level < FULL);
    assign push     = in_valid && in_ready;
    assign pop      = grant && (level != '0);
    assign d_valid  = (level != '0);
    assign d        = d_valid ? mem[rd_ptr] : 8'h00;

    // Storage is left uncleared by reset; level gates what is visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            underrun_cnt <= 8'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      level <= level + (AW+1)'(1);
            else if (pop && !push) level <= level - (AW+1)'(1);
            if (grant && (level == '0) && (underrun_cnt != 8'hFF))
                underrun_cnt <= underrun_cnt + 8'd1;
        end
    end

endmodule
